// File: rtl/calc_pkg.sv
// Shared key codes, operator encodings and sequencer states for the calculator
// keypad front end.
package calc_pkg;

    localparam logic [4:0] K_0    = 5'd0;
    localparam logic [4:0] K_1    = 5'd1;
    localparam logic [4:0] K_2    = 5'd2;
    localparam logic [4:0] K_3    = 5'd3;
    localparam logic [4:0] K_4    = 5'd4;
    localparam logic [4:0] K_5    = 5'd5;
    localparam logic [4:0] K_6    = 5'd6;
    localparam logic [4:0] K_7    = 5'd7;
    localparam logic [4:0] K_8    = 5'd8;
    localparam logic [4:0] K_9    = 5'd9;
    localparam logic [4:0] K_ADD  = 5'd10;
    localparam logic [4:0] K_SUB  = 5'd11;
    localparam logic [4:0] K_MUL  = 5'd12;
    localparam logic [4:0] K_DIV  = 5'd13;
    localparam logic [4:0] K_EQ   = 5'd14;
    localparam logic [4:0] K_CLR  = 5'd15;
    localparam logic [4:0] K_NONE = 5'd31;

    localparam logic [1:0] SG_ADD = 2'b00;
    localparam logic [1:0] SG_SUB = 2'b01;
    localparam logic [1:0] SG_MUL = 2'b10;
    localparam logic [1:0] SG_DIV = 2'b11;

    typedef enum logic [2:0] {
        ENTER1 = 3'd0,
        ENTER2 = 3'd1,
        EXEC   = 3'd2,
        SHOW   = 3'd3,
        ERR    = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [4:0] k);
        return k <= K_9;
    endfunction

    function automatic logic is_oper(input logic [4:0] k);
        return (k >= K_ADD) && (k <= K_DIV);
    endfunction

    function automatic logic [1:0] oper_signo(input logic [4:0] k);
        case (k)
            K_SUB:   return SG_SUB;
            K_MUL:   return SG_MUL;
            K_DIV:   return SG_DIV;
            default: return SG_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Maps a captured cursor position onto the on-screen 4x4 keypad; anything
// outside the grid decodes to K_NONE.
module calc_key_decode
    import calc_pkg::*;
#(
    parameter int KEY_X0 = 64,
    parameter int KEY_Y0 = 160,
    parameter int KEY_W  = 64,
    parameter int KEY_H  = 64
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic [4:0] key_o
);

    // Row-major layout, top row first.
    localparam logic [4:0] MAP [16] = '{
        K_7,   K_8, K_9,  K_ADD,
        K_4,   K_5, K_6,  K_SUB,
        K_1,   K_2, K_3,  K_MUL,
        K_CLR, K_0, K_EQ, K_DIV
    };

    int         dx, dy;
    logic [1:0] col, row;

    always_comb begin
        dx    = $signed({22'b0, x_i}) - KEY_X0;
        dy    = $signed({22'b0, y_i}) - KEY_Y0;
        col   = 2'(dx / KEY_W);
        row   = 2'(dy / KEY_H);
        key_o = K_NONE;
        if (dx >= 0 && dx < 4 * KEY_W && dy >= 0 && dy < 4 * KEY_H)
            key_o = MAP[{row, col}];
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: click edge -> key event -> operand/operator entry,
// ALU launch with start/done handshake, result latch and error handling.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int KEY_X0  = 64,
    parameter int KEY_Y0  = 160,
    parameter int KEY_W   = 64,
    parameter int KEY_H   = 64,
    parameter int MAX_DIG = 4,
    parameter int OPW     = 14,
    parameter int RESW    = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [9:0]      mousex,
    input  logic [9:0]      mousey,
    input  logic            mouseclick,
    input  logic            alu_done,
    input  logic [RESW-1:0] alu_result,
    output logic [OPW-1:0]  primernumero,
    output logic [OPW-1:0]  segundonumero,
    output logic [1:0]      signo,
    output logic            alu_start,
    output logic [RESW-1:0] resultado,
    output logic            show_result,
    output logic            err,
    output logic            busy
);

    localparam int CW = $clog2(MAX_DIG + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic            click_q, kvld_q;
    logic [9:0]      x_q, y_q;
    logic [4:0]      key;
    logic [OPW-1:0]  prim_q, prim_d, seg_q, seg_d;
    logic [1:0]      signo_q, signo_d;
    logic [CW-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [RESW-1:0] res_q, res_d;
    logic            show_q, show_d;
    logic            start_q, start_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            kdig, kop;

    calc_key_decode #(
        .KEY_X0 (KEY_X0),
        .KEY_Y0 (KEY_Y0),
        .KEY_W  (KEY_W),
        .KEY_H  (KEY_H)
    ) u_dec (
        .x_i   (x_q),
        .y_i   (y_q),
        .key_o (key)
    );

    assign kdig = kvld_q && is_digit(key);
    assign kop  = kvld_q && is_oper(key);

    always_comb begin
        state_d = state_q;
        prim_d  = prim_q;
        seg_d   = seg_q;
        signo_d = signo_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        res_d   = res_q;
        show_d  = show_q;
        start_d = 1'b0;
        tmo_d   = '0;

        case (state_q)
            ENTER1: begin
                if (kdig && cnt1_q < CW'(MAX_DIG)) begin
                    prim_d = prim_q * OPW'(10) + OPW'(key);
                    cnt1_d = cnt1_q + 1'b1;
                end else if (kop) begin
                    signo_d = oper_signo(key);
                    state_d = ENTER2;
                end
            end
            ENTER2: begin
                if (kdig && cnt2_q < CW'(MAX_DIG)) begin
                    seg_d  = seg_q * OPW'(10) + OPW'(key);
                    cnt2_d = cnt2_q + 1'b1;
                end else if (kop && cnt2_q == '0) begin
                    signo_d = oper_signo(key);
                end else if (kvld_q && key == K_EQ && cnt2_q != '0) begin
                    if (signo_q == SG_DIV && seg_q == '0) begin
                        state_d = ERR;
                    end else begin
                        start_d = 1'b1;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                tmo_d = tmo_q + 1'b1;
                if (alu_done) begin
                    res_d   = alu_result;
                    show_d  = 1'b1;
                    state_d = SHOW;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end
            end
            SHOW: begin
                // A new digit starts a fresh calculation with that digit.
                if (kdig) begin
                    prim_d  = OPW'(key);
                    cnt1_d  = CW'(1);
                    seg_d   = '0;
                    cnt2_d  = '0;
                    signo_d = SG_ADD;
                    res_d   = '0;
                    show_d  = 1'b0;
                    state_d = ENTER1;
                end
            end
            default: ;
        endcase

        // Clear wins over everything, including an alu_done in the same cycle.
        if (kvld_q && key == K_CLR) begin
            prim_d  = '0;
            seg_d   = '0;
            signo_d = SG_ADD;
            cnt1_d  = '0;
            cnt2_d  = '0;
            res_d   = '0;
            show_d  = 1'b0;
            start_d = 1'b0;
            state_d = ENTER1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTER1;
            click_q <= 1'b0;
            kvld_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            prim_q  <= '0;
            seg_q   <= '0;
            signo_q <= SG_ADD;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            res_q   <= '0;
            show_q  <= 1'b0;
            start_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            click_q <= mouseclick;
            kvld_q  <= mouseclick & ~click_q;
            if (mouseclick & ~click_q) begin
                x_q <= mousex;
                y_q <= mousey;
            end
            state_q <= state_d;
            prim_q  <= prim_d;
            seg_q   <= seg_d;
            signo_q <= signo_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            res_q   <= res_d;
            show_q  <= show_d;
            start_q <= start_d;
            tmo_q   <= tmo_d;
        end
    end

    assign primernumero  = prim_q;
    assign segundonumero = seg_q;
    assign signo         = signo_q;
    assign alu_start     = start_q;
    assign resultado     = res_q;
    assign show_result   = show_q;
    assign err           = (state_q == ERR);
    assign busy          = (state_q == EXEC);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: keypad clicks by pixel position, ALU
// handshake, error paths, clear and reset.
module tb_calc_seq_ctrl;

    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  mousex = '0, mousey = '0;
    logic        mouseclick = 1'b0;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic [13:0] primernumero, segundonumero;
    logic [1:0]  signo;
    logic        alu_start;
    logic [15:0] resultado;
    logic        show_result, err, busy;

    int nvec = 0;
    int nerr = 0;
    int start_cnt = 0;

    calc_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .mousex        (mousex),
        .mousey        (mousey),
        .mouseclick    (mouseclick),
        .alu_done      (alu_done),
        .alu_result    (alu_result),
        .primernumero  (primernumero),
        .segundonumero (segundonumero),
        .signo         (signo),
        .alu_start     (alu_start),
        .resultado     (resultado),
        .show_result   (show_result),
        .err           (err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (alu_start) start_cnt <= start_cnt + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Single-cycle click; the key has taken effect when this returns.
    task automatic press(input int x, input int y);
        mousex     = 10'(x);
        mousey     = 10'(y);
        mouseclick = 1'b1;
        tick(1);
        mouseclick = 1'b0;
        tick(1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".prim"},  32'(primernumero), 0);
        chk({tag, ".seg"},   32'(segundonumero), 0);
        chk({tag, ".signo"}, 32'(signo), 0);
        chk({tag, ".res"},   32'(resultado), 0);
        chk({tag, ".show"},  32'(show_result), 0);
        chk({tag, ".err"},   32'(err), 0);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".start"}, 32'(alu_start), 0);
    endtask

    // Key centres: columns x=96,160,224,288; rows y=192,256,320,384.
    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_zero("reset");

        // Boundary: y=352 is the first pixel of the bottom row (C), x=20 is off-grid.
        press(96, 320);
        chk("bnd.one", 32'(primernumero), 1);
        press(20, 20);
        chk("bnd.none", 32'(primernumero), 1);
        press(96, 352);
        chk("bnd.clr", 32'(primernumero), 0);

        // 12 + 3 = with alu_done 3 cycles after launch
        press(96, 320);
        press(160, 320);
        press(288, 192);
        press(224, 320);
        press(224, 384);
        chk("t1.start", 32'(alu_start), 1);
        chk("t1.busy", 32'(busy), 1);
        tick(2);
        alu_result = 16'd15;
        alu_done   = 1'b1;
        tick(1);
        alu_done   = 1'b0;
        chk("t1.signo", 32'(signo), 0);
        chk("t1.prim", 32'(primernumero), 12);
        chk("t1.seg", 32'(segundonumero), 3);
        chk("t1.res", 32'(resultado), 15);
        chk("t1.show", 32'(show_result), 1);
        chk("t1.busy0", 32'(busy), 0);
        chk("t1.nstart", 32'(start_cnt), 1);
        press(288, 256);
        chk("t1.opign", 32'(signo), 0);

        // From SHOW, "98765" restarts entry; fifth digit dropped
        press(224, 192);
        chk("t2.show0", 32'(show_result), 0);
        chk("t2.res0", 32'(resultado), 0);
        press(160, 192);
        press(96, 192);
        press(224, 256);
        press(160, 256);
        chk("t2.prim", 32'(primernumero), 9876);

        // Click held 100 cycles gives one digit only
        press(96, 384);
        mousex = 10'd96; mousey = 10'd192; mouseclick = 1'b1;
        tick(100);
        mouseclick = 1'b0;
        tick(2);
        chk("t2.hold", 32'(primernumero), 7);
        press(96, 192);
        chk("t2.again", 32'(primernumero), 77);

        // 8 / 0 = -> divide by zero
        press(96, 384);
        press(160, 192);
        press(288, 384);
        press(160, 384);
        press(224, 384);
        tick(1);
        chk("t3.err", 32'(err), 1);
        chk("t3.nstart", 32'(start_cnt), 1);
        press(160, 256);
        chk("t3.dig", 32'(primernumero), 8);
        chk("t3.seg", 32'(segundonumero), 0);
        chk("t3.signo", 32'(signo), 3);
        press(96, 384);
        chk_zero("t3.clr");

        // 4 + - 2 * : operator replaced before operand 2, kept after
        press(96, 256);
        press(288, 192);
        press(288, 256);
        chk("t4.repl", 32'(signo), 1);
        press(160, 320);
        press(288, 320);
        chk("t4.keep", 32'(signo), 1);
        chk("t4.seg", 32'(segundonumero), 2);
        chk("t4.prim", 32'(primernumero), 4);

        // Launch and never answer: err exactly TIMEOUT cycles after EXEC entry
        press(224, 384);
        chk("t5.busy", 32'(busy), 1);
        tick(TIMEOUT - 1);
        chk("t5.pre", 32'(err), 0);
        chk("t5.prebusy", 32'(busy), 1);
        tick(1);
        chk("t5.err", 32'(err), 1);
        chk("t5.busy0", 32'(busy), 0);
        chk("t5.nstart", 32'(start_cnt), 2);

        // Abort with C during EXEC; late alu_done is ignored
        press(96, 384);
        press(224, 256);
        press(288, 192);
        press(96, 320);
        press(224, 384);
        chk("t6.busy", 32'(busy), 1);
        tick(2);
        press(96, 384);
        chk("t6.abort", 32'(busy), 0);
        alu_result = 16'd7;
        alu_done   = 1'b1;
        tick(1);
        alu_done   = 1'b0;
        tick(1);
        chk("t6.res", 32'(resultado), 0);
        chk("t6.show", 32'(show_result), 0);
        chk("t6.nstart", 32'(start_cnt), 3);

        // Reset mid-entry
        press(224, 320);
        press(96, 256);
        press(288, 192);
        press(160, 256);
        chk("t7.pre", 32'(primernumero), 34);
        reset = 1'b1;
        tick(1);
        chk_zero("t7.rst");
        reset = 1'b0;
        press(160, 256);
        chk("t7.after", 32'(primernumero), 5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
